// File: rtl/led_pkg.sv
//------------------------------------------------------------------------------
// Module      : led_pkg
// Description : Shared mode and direction types for the LED pattern generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } led_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } led_dir_e;

endpackage : led_pkg

`default_nettype wire

// File: rtl/led_prescaler.sv
//------------------------------------------------------------------------------
// Module      : led_prescaler
// Description : Divide-by-DIV strobe generator with synchronous clear and hold.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_prescaler #(
    parameter int DIV = 1200000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int              c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("led_prescaler: DIV must be at least 2");
        end
    endgenerate

    logic [c_cnt_w-1:0] r_cnt;

    // clr wins over hold so a restart is never lost while frozen
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (!hold) begin
            if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign tick = (r_cnt == c_last) && !hold;

endmodule : led_prescaler

`default_nettype wire

// File: rtl/led_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : led_pattern_gen
// Description : Multi-mode LED pattern generator (off/blink/chase/bounce) with
//               prescaled stepping, PWM brightness and pause.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int TICK_DIV = 1200000,
    parameter int PWM_BITS = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [1:0]          MODE,
    input  logic [PWM_BITS-1:0] BRIGHT,
    input  logic                PAUSE,
    output logic [NUM_LEDS-1:0] LEDS,
    output logic                STEP
);

    localparam logic [NUM_LEDS-1:0] c_one = NUM_LEDS'(1);

    generate
        if (NUM_LEDS < 2) begin : g_leds_check
            $error("led_pattern_gen: NUM_LEDS must be at least 2");
        end
        if (TICK_DIV < 2) begin : g_div_check
            $error("led_pattern_gen: TICK_DIV must be at least 2");
        end
    endgenerate

    led_mode_e           r_mode_q;
    led_mode_e           w_mode_nxt;
    led_mode_e           w_mode_in;
    led_dir_e            r_dir;
    led_dir_e            w_dir_nxt;
    logic [NUM_LEDS-1:0] r_pat;
    logic [NUM_LEDS-1:0] w_pat_nxt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LEDS-1:0] r_leds;
    logic                r_step;
    logic                w_step;
    logic                w_tick;
    logic                w_mode_chg;
    logic                w_en;

    assign w_mode_in  = led_mode_e'(MODE);
    assign w_mode_chg = (w_mode_in != r_mode_q);

    led_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (w_mode_chg),
        .hold (PAUSE),
        .tick (w_tick)
    );

    // A mode change swallows a coincident tick; OFF never reports a step
    always_comb begin
        w_mode_nxt = r_mode_q;
        w_dir_nxt  = r_dir;
        w_pat_nxt  = r_pat;
        w_step     = 1'b0;
        if (w_mode_chg) begin
            w_mode_nxt = w_mode_in;
            w_dir_nxt  = DIR_UP;
            case (w_mode_in)
                MODE_OFF:   w_pat_nxt = '0;
                MODE_BLINK: w_pat_nxt = '1;
                default:    w_pat_nxt = c_one;
            endcase
        end else if (w_tick) begin
            case (r_mode_q)
                MODE_OFF: begin
                    w_pat_nxt = '0;
                end
                MODE_BLINK: begin
                    w_pat_nxt = ~r_pat;
                    w_step    = 1'b1;
                end
                MODE_CHASE: begin
                    w_pat_nxt = {r_pat[NUM_LEDS-2:0], r_pat[NUM_LEDS-1]};
                    w_step    = 1'b1;
                end
                MODE_BOUNCE: begin
                    w_step = 1'b1;
                    if (r_dir == DIR_UP) begin
                        if (r_pat[NUM_LEDS-1]) begin
                            w_dir_nxt = DIR_DOWN;
                            w_pat_nxt = r_pat >> 1;
                        end else begin
                            w_pat_nxt = r_pat << 1;
                        end
                    end else begin
                        if (r_pat[0]) begin
                            w_dir_nxt = DIR_UP;
                            w_pat_nxt = r_pat << 1;
                        end else begin
                            w_pat_nxt = r_pat >> 1;
                        end
                    end
                end
                default: begin
                    w_pat_nxt = r_pat;
                end
            endcase
        end
    end

    // Full-scale brightness bypasses the compare so it is truly always on
    assign w_en = (&BRIGHT) ? 1'b1 : (r_pwm_cnt < BRIGHT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mode_q  <= MODE_OFF;
            r_dir     <= DIR_UP;
            r_pat     <= '0;
            r_pwm_cnt <= '0;
            r_leds    <= '0;
            r_step    <= 1'b0;
        end else begin
            r_mode_q  <= w_mode_nxt;
            r_dir     <= w_dir_nxt;
            r_pat     <= w_pat_nxt;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_leds    <= r_pat & {NUM_LEDS{w_en}};
            r_step    <= w_step;
        end
    end

    assign LEDS = r_leds;
    assign STEP = r_step;

endmodule : led_pattern_gen

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_led_pattern_gen
// Description : Directed self-checking bench for led_pattern_gen (8 LEDs,
//               TICK_DIV=4, PWM_BITS=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_pattern_gen;

    logic       CLK;
    logic       RST;
    logic [1:0] MODE;
    logic [3:0] BRIGHT;
    logic       PAUSE;
    logic [7:0] LEDS;
    logic       STEP;

    int checks = 0;
    int errors = 0;

    led_pattern_gen #(
        .NUM_LEDS (8),
        .TICK_DIV (4),
        .PWM_BITS (4)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .MODE   (MODE),
        .BRIGHT (BRIGHT),
        .PAUSE  (PAUSE),
        .LEDS   (LEDS),
        .STEP   (STEP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; MODE = 2'd0; BRIGHT = 4'hF; PAUSE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (LEDS !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h expected 00", LEDS); end
            checks++;
            if (STEP !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", STEP); end
        end
    endtask

    task automatic test_chase();
        logic [7:0] exp;
        RST = 1'b0; MODE = 2'd2;
        step();
        checks++;
        if (LEDS !== 8'h00 || STEP !== 1'b0) begin
            errors++; $display("FAIL chase_load: got leds=%h step=%b expected leds=00 step=0", LEDS, STEP);
        end
        for (int k = 0; k < 9; k++) begin
            exp = 8'h01 << (k % 8);
            for (int j = 0; j < 4; j++) begin
                step();
                checks++;
                if (LEDS !== exp) begin errors++; $display("FAIL chase_leds k=%0d j=%0d: got %h expected %h", k, j, LEDS, exp); end
                checks++;
                if (STEP !== (j == 3)) begin errors++; $display("FAIL chase_step k=%0d j=%0d: got %b expected %b", k, j, STEP, (j == 3)); end
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        MODE = 2'd3;
        step();
        checks++;
        if (STEP !== 1'b0) begin errors++; $display("FAIL bounce_load_step: got %b expected 0", STEP); end
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 4; j++) begin
                step();
                checks++;
                if (LEDS !== seq[k]) begin errors++; $display("FAIL bounce_leds k=%0d j=%0d: got %h expected %h", k, j, LEDS, seq[k]); end
                checks++;
                if (STEP !== (j == 3)) begin errors++; $display("FAIL bounce_step k=%0d j=%0d: got %b expected %b", k, j, STEP, (j == 3)); end
            end
        end
    endtask

    task automatic test_blink_off();
        logic [7:0] exp;
        MODE = 2'd1;
        step();
        checks++;
        if (STEP !== 1'b0) begin errors++; $display("FAIL blink_load_step: got %b expected 0", STEP); end
        for (int k = 0; k < 6; k++) begin
            exp = (k % 2 == 0) ? 8'hFF : 8'h00;
            for (int j = 0; j < 4; j++) begin
                step();
                checks++;
                if (LEDS !== exp) begin errors++; $display("FAIL blink_leds k=%0d j=%0d: got %h expected %h", k, j, LEDS, exp); end
                checks++;
                if (STEP !== (j == 3)) begin errors++; $display("FAIL blink_step k=%0d j=%0d: got %b expected %b", k, j, STEP, (j == 3)); end
            end
        end
        MODE = 2'd0;
        step();
        checks++;
        if (STEP !== 1'b0) begin errors++; $display("FAIL off_load_step: got %b expected 0", STEP); end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (LEDS !== 8'h00 || STEP !== 1'b0) begin
                errors++; $display("FAIL off_idle i=%0d: got leds=%h step=%b expected leds=00 step=0", i, LEDS, STEP);
            end
        end
    endtask

    task automatic test_pwm_pause();
        int ones;
        PAUSE = 1'b1; MODE = 2'd1; BRIGHT = 4'd5;
        step();
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (LEDS === 8'hFF) ones++;
            checks++;
            if ((LEDS !== 8'hFF && LEDS !== 8'h00) || STEP !== 1'b0) begin
                errors++; $display("FAIL pwm5_level i=%0d: got leds=%h step=%b expected leds=00/FF step=0", i, LEDS, STEP);
            end
        end
        checks++;
        if (ones != 5) begin errors++; $display("FAIL pwm5_duty: got %0d on-cycles expected 5", ones); end
        BRIGHT = 4'd0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (LEDS !== 8'h00 || STEP !== 1'b0) begin
                errors++; $display("FAIL pwm0 i=%0d: got leds=%h step=%b expected leds=00 step=0", i, LEDS, STEP);
            end
        end
        BRIGHT = 4'hF;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (LEDS !== 8'hFF || STEP !== 1'b0) begin
                errors++; $display("FAIL pwm15_pause i=%0d: got leds=%h step=%b expected leds=FF step=0", i, LEDS, STEP);
            end
        end
    endtask

    task automatic test_mode_change_on_tick();
        PAUSE = 1'b0; BRIGHT = 4'hF; MODE = 2'd2;
        step();
        repeat (15) step();
        checks++;
        if (LEDS !== 8'h08 || STEP !== 1'b0) begin
            errors++; $display("FAIL chg_pre: got leds=%h step=%b expected leds=08 step=0", LEDS, STEP);
        end
        MODE = 2'd3;
        step();
        checks++;
        if (STEP !== 1'b0) begin errors++; $display("FAIL chg_dropped_step: got %b expected 0", STEP); end
        step();
        checks++;
        if (LEDS !== 8'h01 || STEP !== 1'b0) begin
            errors++; $display("FAIL chg_first: got leds=%h step=%b expected leds=01 step=0", LEDS, STEP);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (STEP !== 1'b0) begin errors++; $display("FAIL chg_wait i=%0d: got %b expected 0", i, STEP); end
        end
        step();
        checks++;
        if (STEP !== 1'b1 || LEDS !== 8'h01) begin
            errors++; $display("FAIL chg_step4: got leds=%h step=%b expected leds=01 step=1", LEDS, STEP);
        end
        step();
        checks++;
        if (LEDS !== 8'h02) begin errors++; $display("FAIL chg_next: got %h expected 02", LEDS); end
    endtask

    task automatic test_reset_mid_run();
        MODE = 2'd2;
        step();
        repeat (20) step();
        checks++;
        if (STEP !== 1'b1) begin errors++; $display("FAIL midrst_pre_step: got %b expected 1", STEP); end
        step();
        checks++;
        if (LEDS !== 8'h20) begin errors++; $display("FAIL midrst_pre_leds: got %h expected 20", LEDS); end
        RST = 1'b1;
        step();
        checks++;
        if (LEDS !== 8'h00 || STEP !== 1'b0) begin
            errors++; $display("FAIL midrst_clear: got leds=%h step=%b expected leds=00 step=0", LEDS, STEP);
        end
        RST = 1'b0;
        step();
        checks++;
        if (LEDS !== 8'h00 || STEP !== 1'b0) begin
            errors++; $display("FAIL midrst_reload: got leds=%h step=%b expected leds=00 step=0", LEDS, STEP);
        end
        for (int j = 0; j < 4; j++) begin
            step();
            checks++;
            if (LEDS !== 8'h01 || STEP !== (j == 3)) begin
                errors++; $display("FAIL midrst_restart j=%0d: got leds=%h step=%b expected leds=01 step=%b", j, LEDS, STEP, (j == 3));
            end
        end
        step();
        checks++;
        if (LEDS !== 8'h02) begin errors++; $display("FAIL midrst_next: got %h expected 02", LEDS); end
    endtask

    initial begin
        RST = 1'b1; MODE = 2'd0; BRIGHT = 4'hF; PAUSE = 1'b0;
        test_reset();
        test_chase();
        test_bounce();
        test_blink_off();
        test_pwm_pause();
        test_mode_change_on_tick();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_led_pattern_gen

`default_nettype wire

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED driver: generalises the free-running blink counter into a multi-mode pattern generator.
- Features: NUM_LEDS outputs, runtime mode select (off / blink / chase / bounce), prescaled step rate, PWM brightness, pause.
- Sits between board-level control (switches or a future UART register) and the LED pins.
- Top-level integration ties MODE, BRIGHT and PAUSE to constants or inputs.

Parameters:
NUM_LEDS, 8, LED output count; elaboration error if < 2
TICK_DIV, 1200000, CLK cycles per pattern step (10 Hz at 12 MHz); elaboration error if < 2
PWM_BITS, 4, brightness resolution; PWM period = 2**PWM_BITS cycles

Ports:
CLK  input  1  system clock, 12 MHz
RST  input  1  synchronous, active-high reset
MODE  input  2  pattern select: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE
BRIGHT  input  PWM_BITS  duty level; 0 = dark, all-ones = fully on
PAUSE  input  1  1 = freeze prescaler and pattern; PWM keeps running
LEDS  output  NUM_LEDS  registered LED drive, bit 0 = LED0
STEP  output  1  registered one-cycle pulse per pattern advance

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high. While RST is high, every register clears on each CLK edge: tick_cnt, pat, dir (up), mode_q (OFF), pwm_cnt, LEDS = 0, STEP = 0.
- Prescaler:
  - tick_cnt is $clog2(TICK_DIV) bits wide and counts 0..TICK_DIV-1, then wraps to 0.
  - tick is combinational: tick = (tick_cnt == TICK_DIV-1) && !PAUSE.
  - PAUSE=1 holds tick_cnt.
- Mode change:
  - Each cycle, if MODE != mode_q: mode_q <= MODE, tick_cnt <= 0, pat <= initial pattern, dir <= up.
  - Initial patterns: OFF = 0, BLINK = all ones, CHASE = 1, BOUNCE = 1.
  - A mode change has priority over a coincident tick. The tick is dropped and no STEP is issued.
  - Mode change applies even while PAUSE=1.
- Step on tick (no mode change in that cycle):
  - OFF: pat stays 0.
  - BLINK: pat <= ~pat.
  - CHASE: rotate left; bit NUM_LEDS-1 wraps to bit 0.
  - BOUNCE, dir up: if pat[NUM_LEDS-1], then dir <= down and pat <= pat>>1; otherwise pat <= pat<<1.
  - BOUNCE, dir down: if pat[0], then dir <= up and pat <= pat<<1; otherwise pat <= pat>>1.
  - BOUNCE period is 2*NUM_LEDS-2 steps. The end LEDs are never shown twice in a row.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps.
  - en = (BRIGHT == all ones) ? 1 : (pwm_cnt < BRIGHT).
  - BRIGHT is sampled every cycle with no synchronisation. Callers must supply CLK-domain values.
- Outputs:
  - LEDS <= pat & {NUM_LEDS{en}}, i.e. one cycle of latency from pat.
  - STEP <= tick && no mode change. STEP is high in the cycle pat first holds the new value; LEDS shows that value one cycle later.
- After reset release with MODE != OFF: the first cycle loads the initial pattern via the mode-change path. LEDS shows it on the second cycle, subject to PWM.
- RST mid-operation: outputs are 0 on the next edge and the pattern restarts from its initial value.

Decomposition:
- Package led_pkg:
  - typedef enum logic [1:0] led_mode_e {MODE_OFF, MODE_BLINK, MODE_CHASE, MODE_BOUNCE}
  - typedef enum logic {DIR_UP, DIR_DOWN} led_dir_e
- Sub-module led_prescaler:
  - Parameter DIV.
  - Ports: CLK, RST, clr, hold, tick.
  - Reused by later blocks needing slow strobes.
- The pattern FSM and PWM stay in led_pattern_gen.

Test Plan (NUM_LEDS=8, TICK_DIV=4, PWM_BITS=4):
1. RST 2 cycles, then MODE=CHASE, BRIGHT=15 -> LEDS = 0x01, 0x02, ..., 0x80, 0x01, each held 4 cycles; STEP pulses every 4 cycles, 8 pulses per lap.
2. MODE=BOUNCE, BRIGHT=15 -> LEDS sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02; 14-step period, no repeated 0x80 or 0x01.
3. MODE=BLINK, BRIGHT=15 -> LEDS alternates 0xFF / 0x00 every 4 cycles; MODE=OFF -> LEDS = 0x00, no STEP.
4. MODE=BLINK, PAUSE=1, BRIGHT=5 -> LEDS = 0xFF exactly 5 of every 16 cycles, no STEP; BRIGHT=0 -> always 0x00; BRIGHT=15 -> always 0xFF.
5. CHASE at pat=0x08, switch MODE to BOUNCE in a tick cycle -> no STEP that cycle; LEDS = 0x01 next; next STEP exactly 4 cycles after the change.
6. CHASE running, RST high 1 cycle at pat=0x20 -> LEDS=0x00 and STEP=0 the following cycle; after release, pattern restarts at 0x01 with full 4-cycle first step.
